display_scanner: RTL

//  Time-multiplexes a packed NUM_DIGITS-digit hex value onto one shared 7-segment bus.

---
 rtl/display_scanner_pkg.sv | 18 +
 rtl/display_scanner_if.sv | 24 ++
 rtl/display_scanner_prescaler.sv | 27 ++
 rtl/display_scanner.sv | 104 ++++++++++
 4 files changed

// File: rtl/display_scanner_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display scanner.
package display_pkg;

    localparam int DIGIT_W            = 4;
    localparam int DEFAULT_NUM_DIGITS = 4;
    // Widest anode vector idx2anode can build; NUM_DIGITS must stay below this.
    localparam int MAX_DIGITS         = 32;

    typedef logic [DIGIT_W-1:0] nibble_t;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [MAX_DIGITS-1:0] idx2anode(input int unsigned idx);
        logic [MAX_DIGITS-1:0] one;
        one = MAX_DIGITS'(1);
        return ~(one << idx);
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Display scanner bus: load/data toward the scanner, decoder/anode drive back out.
interface display_scanner_if #(
    parameter int NUM_DIGITS = 4
) ();

    logic [4*NUM_DIGITS-1:0]         data_in;
    logic                            load;
    logic [NUM_DIGITS-1:0]           digit_en;
    logic [3:0]                      nibble_out;
    logic [NUM_DIGITS-1:0]           an_out;
    logic [$clog2(NUM_DIGITS)-1:0]   digit_idx;
    logic                            pending;

    modport master (
        output data_in, load, digit_en,
        input  nibble_out, an_out, digit_idx, pending
    );

    modport slave (
        input  data_in, load, digit_en,
        output nibble_out, an_out, digit_idx, pending
    );

endinterface

// File: rtl/display_scanner_prescaler.sv
// Slot-rate prescaler: counts 0..DIV-1, tick flags the terminal count.
module refresh_prescaler #(
    parameter int DIV = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   tick,
    output logic [$clog2(DIV)-1:0] count
);

    localparam int            CW = $clog2(DIV);
    localparam logic [CW-1:0] TC = CW'(DIV - 1);

    assign tick = (count == TC);

    // Free-running slot counter, wraps on terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed hex display scanner with frame-aligned value commit.
// Optional LEADING_ZERO_BLANK_EN: blank leading-zero digits above digit 0.
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    display_scanner_if.slave   bus
);

    localparam int              W        = DIGIT_W * NUM_DIGITS;
    localparam int              IW       = $clog2(NUM_DIGITS);
    localparam int              CW       = $clog2(REFRESH_DIV);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0]   DEAD_TC  = CW'(DEAD_CYCLES);

    logic                    tick;
    logic [CW-1:0]           count;
    logic [IW-1:0]           idx;
    logic [W-1:0]            shown;
    logic [W-1:0]            pending_val;
    logic                    pending_q;
    nibble_t                 nibble_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [NUM_DIGITS-1:0]   blank;
    logic [MAX_DIGITS-1:0]   anode_full;
    logic                    wrap;
    logic                    slot_lit;
    logic                    unused_anode_bits;

    refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .count (count)
    );

    // Per-digit blanking derived from the committed value.
    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 1; i < NUM_DIGITS; i++) begin
            blank[i] = ((shown >> (DIGIT_W * i)) == '0);
        end
`endif
    end

    // Slot decode: anode pattern, frame wrap, and whether this cycle's digit is lit.
    always_comb begin
        anode_full = idx2anode(32'(idx));
        wrap       = tick && (idx == LAST_IDX);
        slot_lit   = (count >= DEAD_TC) && bus.digit_en[idx] && !blank[idx];
    end

    assign unused_anode_bits = ^anode_full[MAX_DIGITS-1:NUM_DIGITS];

    // Digit slot index advances once per prescaler period.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // Load staging and frame-boundary commit; a load on the wrap bypasses staging.
    always_ff @(posedge clk) begin
        if (reset) begin
            shown       <= '0;
            pending_val <= '0;
            pending_q   <= 1'b0;
        end else if (bus.load && wrap) begin
            shown     <= bus.data_in;
            pending_q <= 1'b0;
        end else if (bus.load) begin
            pending_val <= bus.data_in;
            pending_q   <= 1'b1;
        end else if (wrap && pending_q) begin
            shown     <= pending_val;
            pending_q <= 1'b0;
        end
    end

    // Registered decoder nibble and anode drive for the current slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            nibble_q <= '0;
            an_q     <= '1;
        end else begin
            nibble_q <= shown[DIGIT_W*idx +: DIGIT_W];
            an_q     <= slot_lit ? anode_full[NUM_DIGITS-1:0] : '1;
        end
    end

    assign bus.nibble_out = nibble_q;
    assign bus.an_out     = an_q;
    assign bus.digit_idx  = idx;
    assign bus.pending    = pending_q;

endmodule
